// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Request/UART-side bundle for uart_tx_arbiter.
//            master = arbiter, slave = encoders plus UART FIFO side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_full;
    logic               wr_uart;
    logic [7:0]         w_data;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic               abort;

    modport master (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, wr_uart, w_data, grant_id, busy, abort
    );

    modport slave (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, wr_uart, w_data, grant_id, busy, abort
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, frame-atomic sharing of one UART TX path with a
//            stall timeout. Optional trailing XOR checksum: UART_ARB_CHKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_arbiter_if.master bus
);
    localparam int GW    = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]    PTR_RST  = GW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    grant_q,  grant_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
`ifdef UART_ARB_CHKSUM_EN
    logic [7:0]       chk_q,    chk_d;
`endif

    logic             w_pick_found;
    logic [GW-1:0]    w_pick_idx;
    logic [GW-1:0]    w_scan_idx;
    logic             w_gnt_valid;
    logic             w_gnt_last;
    logic [7:0]       w_gnt_data;
    logic             w_accept;

    assign w_gnt_valid = bus.req_valid[grant_q];
    assign w_gnt_last  = bus.req_last[grant_q];
    assign w_gnt_data  = bus.req_data[{grant_q, 3'b000} +: 8];

    // Scan starts one past the last served requester and wraps at N_REQ-1.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = (w_scan_idx == PTR_RST) ? '0 : w_scan_idx + GW'(1);
            if (!w_pick_found && bus.req_valid[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
`ifdef UART_ARB_CHKSUM_EN
        chk_d         = chk_q;
`endif
        w_accept      = 1'b0;
        bus.wr_uart   = 1'b0;
        bus.w_data    = 8'h00;
        bus.req_ready = '0;
        bus.busy      = 1'b0;
        bus.abort     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_found) begin
                    grant_d = w_pick_idx;
                    cnt_d   = '0;
`ifdef UART_ARB_CHKSUM_EN
                    chk_d   = 8'h00;
`endif
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                bus.busy               = 1'b1;
                w_accept               = w_gnt_valid & ~bus.tx_full;
                bus.wr_uart            = w_accept;
                bus.w_data             = w_gnt_data;
                bus.req_ready[grant_q] = w_accept;
                if (w_accept) begin
                    cnt_d = '0;
`ifdef UART_ARB_CHKSUM_EN
                    chk_d = chk_q ^ w_gnt_data;
`endif
                    if (w_gnt_last) begin
                        rr_ptr_d = grant_q;
`ifdef UART_ARB_CHKSUM_EN
                        state_d  = ST_CHK;
`else
                        state_d  = ST_IDLE;
`endif
                    end
                end else if (!w_gnt_valid && (TIMEOUT_CYCLES != 0)) begin
                    // A held byte blocked by tx_full is not idleness; only a missing byte counts.
                    if (cnt_q == CNT_LAST) begin
                        bus.abort = 1'b1;
                        rr_ptr_d  = grant_q;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef UART_ARB_CHKSUM_EN
            ST_CHK: begin
                bus.busy    = 1'b1;
                bus.wr_uart = ~bus.tx_full;
                bus.w_data  = chk_q;
                if (!bus.tx_full) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.grant_id = grant_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= PTR_RST;
            grant_q  <= '0;
            cnt_q    <= '0;
`ifdef UART_ARB_CHKSUM_EN
            chk_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
`ifdef UART_ARB_CHKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed scenarios plus randomized traffic against a frame-level
//            reference model of uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int QD = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Per-requester byte queues: {last, data}
    logic [8:0]   fbuf [N][QD];
    int           head [N];
    int           tail [N];
    int           pause[N];
    bit           gaps_en = 1'b0;
    logic [N-1:0] m_acc = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i]  = 0;
            tail[i]  = 0;
            pause[i] = 0;
        end
    end

    task automatic push(input int r, input logic [7:0] d, input bit last);
        if (tail[r] < QD) begin
            fbuf[r][tail[r]] = {last, d};
            tail[r]++;
        end
    endtask

    // Requester agents: hold an offered byte until accepted; queues flush during reset.
    always @(posedge clk) begin
        bit hold;
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rst) head[i] = tail[i];
            if (m_acc[i]) begin
                head[i]++;
                if (gaps_en && ($urandom % 25 == 0)) pause[i] = $urandom_range(6, 12);
            end
            hold = rst && bus.req_valid[i] && !m_acc[i];
            if (!hold) begin
                if (head[i] >= tail[i] || pause[i] > 0 || (gaps_en && ($urandom % 8 == 0))) begin
                    bus.req_valid[i] = 1'b0;
                    if (pause[i] > 0) pause[i]--;
                end else begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_last[i]          = fbuf[i][head[i]][8];
                    bus.req_data[8*i +: 8]   = fbuf[i][head[i]][7:0];
                end
            end
        end
    end

    // Reference model: owner=-1 means no frame in progress.
    int         m_owner  = -1;
    bit         m_in_chk = 1'b0;
    int         m_ptr    = N - 1;
    int         m_gid    = 0;
    int         m_idle   = 0;
    logic [7:0] m_chk    = 8'h00;

    always @(negedge clk) begin
        int e_wr, e_data, e_ready, e_busy, e_abort, g;
        bit cmp_data, acc;
        m_acc = '0;
        if (!rst) begin
            m_owner = -1; m_in_chk = 1'b0; m_ptr = N - 1; m_gid = 0; m_idle = 0; m_chk = 8'h00;
            check("rst_wr_uart", int'(bus.wr_uart), 0);
            check("rst_req_ready", int'(bus.req_ready), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_abort", int'(bus.abort), 0);
            check("rst_w_data", int'(bus.w_data), 0);
            check("rst_grant_id", int'(bus.grant_id), 0);
        end else begin
            e_wr = 0; e_data = 0; e_ready = 0; e_busy = 0; e_abort = 0; cmp_data = 1'b1;
            check("grant_id", int'(bus.grant_id), m_gid);
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && bus.req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                if (m_owner >= 0) begin
                    m_gid = m_owner; m_idle = 0; m_chk = 8'h00;
                end
            end else if (m_in_chk) begin
                e_busy = 1; e_wr = int'(!bus.tx_full); e_data = int'(m_chk); cmp_data = !bus.tx_full;
                if (!bus.tx_full) begin
                    m_owner = -1; m_in_chk = 1'b0;
                end
            end else begin
                g        = m_owner;
                e_busy   = 1;
                acc      = bus.req_valid[g] && !bus.tx_full;
                e_wr     = int'(acc);
                e_data   = int'(bus.req_data[8*g +: 8]);
                e_ready  = acc ? (1 << g) : 0;
                cmp_data = acc;
                m_acc[g] = acc;
                if (acc) begin
                    m_chk  = m_chk ^ bus.req_data[8*g +: 8];
                    m_idle = 0;
                    if (bus.req_last[g]) begin
                        m_ptr = g;
`ifdef UART_ARB_CHKSUM_EN
                        m_in_chk = 1'b1;
`else
                        m_owner  = -1;
`endif
                    end
                end else if (!bus.req_valid[g]) begin
                    m_idle++;
                    if (m_idle == TO) begin
                        e_abort = 1; m_ptr = g; m_owner = -1;
                    end
                end
            end
            check("wr_uart", int'(bus.wr_uart), e_wr);
            check("req_ready", int'(bus.req_ready), e_ready);
            check("busy", int'(bus.busy), e_busy);
            check("abort", int'(bus.abort), e_abort);
            if (cmp_data) check("w_data", int'(bus.w_data), e_data);
        end
    end

    // Write and abort logs for the directed, literal expectations.
    logic [7:0] wlog_d[$];
    int         wlog_g[$];
    int         wlog_c[$];
    int         ab_n = 0;
    always @(negedge clk) begin
        if (rst && bus.wr_uart) begin
            wlog_d.push_back(bus.w_data);
            wlog_g.push_back(int'(bus.grant_id));
            wlog_c.push_back(cyc);
        end
    end
    always @(negedge clk) if (bus.abort) ab_n++;

    logic [7:0] ex[$];
    int         wbase;

    task automatic check_log(input string name);
        check({name, "_count"}, wlog_d.size() - wbase, ex.size());
        for (int k = 0; k < ex.size() && (wbase + k) < wlog_d.size(); k++)
            check({name, "_byte"}, int'(wlog_d[wbase + k]), int'(ex[k]));
    endtask

    task automatic wait_wr(input string name, output int c);
        c = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.wr_uart) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: got no write within 20 cycles, expected a write", name);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int rq_cyc, acc_cyc, ab_cyc, c, ab0, len;
        bus.tx_full = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            check("idle_wr_uart", int'(bus.wr_uart), 0);
            check("idle_busy", int'(bus.busy), 0);
            check("idle_grant_id", int'(bus.grant_id), 0);
        end

        // Single frame from requester 2
        @(posedge clk); #2;
        wbase = wlog_d.size();
        push(2, 8'h41, 0); push(2, 8'h42, 0); push(2, 8'h43, 1);
        rq_cyc = -100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.req_valid[2]) begin rq_cyc = cyc; break; end
        end
        repeat (8) @(posedge clk);
        #2;
        ex.delete();
        ex.push_back(8'h41); ex.push_back(8'h42); ex.push_back(8'h43);
`ifdef UART_ARB_CHKSUM_EN
        ex.push_back(8'h40);
`endif
        check_log("frame_r2");
        for (int k = 0; k < 3 && (wbase + k) < wlog_c.size(); k++) begin
            check("frame_r2_latency", wlog_c[wbase + k] - rq_cyc, k + 1);
            check("frame_r2_gid", wlog_g[wbase + k], 2);
        end

        // Contention between 0 and 3, alternating order
        pulse_reset();
        wbase = wlog_d.size();
        push(0, 8'hA0, 0); push(0, 8'hA1, 1); push(0, 8'hA0, 0); push(0, 8'hA1, 1);
        push(3, 8'hB0, 0); push(3, 8'hB1, 1); push(3, 8'hB0, 0); push(3, 8'hB1, 1);
        repeat (30) @(posedge clk);
        #2;
        ex.delete();
        for (int f = 0; f < 2; f++) begin
            ex.push_back(8'hA0); ex.push_back(8'hA1);
`ifdef UART_ARB_CHKSUM_EN
            ex.push_back(8'h01);
`endif
            ex.push_back(8'hB0); ex.push_back(8'hB1);
`ifdef UART_ARB_CHKSUM_EN
            ex.push_back(8'h01);
`endif
        end
        check_log("rr_order");
        if (wlog_g.size() > wbase) check("rr_first_gid", wlog_g[wbase], 0);
        if (wlog_g.size() > wbase) check("rr_last_gid", wlog_g[wlog_g.size() - 1], 3);

        // tx_full stall mid-frame
        wbase = wlog_d.size();
        ab0   = ab_n;
        push(1, 8'h10, 0); push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 1);
        wait_wr("stall_first", c);
        @(posedge clk); #2 bus.tx_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_wr_uart", int'(bus.wr_uart), 0);
            check("stall_req_ready", int'(bus.req_ready), 0);
        end
        @(posedge clk); #2 bus.tx_full = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        ex.delete();
        ex.push_back(8'h10); ex.push_back(8'h11); ex.push_back(8'h12); ex.push_back(8'h13);
`ifdef UART_ARB_CHKSUM_EN
        ex.push_back(8'h00);
`endif
        check_log("stall_seq");
        check("stall_no_abort", ab_n - ab0, 0);

        // Timeout on requester 1, requester 2 waiting
        push(1, 8'h55, 0);
        wait_wr("timeout_first", acc_cyc);
        push(2, 8'h66, 1);
        ab_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.abort) begin ab_cyc = cyc; break; end
        end
        check("abort_delay", ab_cyc - acc_cyc, TO);
        @(negedge clk);
        check("abort_busy_next", int'(bus.busy), 0);
        wait_wr("after_abort", c);
        check("after_abort_gid", int'(bus.grant_id), 2);
        check("after_abort_data", int'(bus.w_data), 8'h66);
        repeat (4) @(posedge clk);

        // Asynchronous reset during SEND
        push(3, 8'h01, 0); push(3, 8'h02, 0); push(3, 8'h03, 0); push(3, 8'h04, 0); push(3, 8'h05, 1);
        wait_wr("async_first", c);
        #2 rst = 1'b0;
        #1;
        check("async_wr_uart", int'(bus.wr_uart), 0);
        check("async_busy", int'(bus.busy), 0);
        check("async_req_ready", int'(bus.req_ready), 0);
        check("async_abort", int'(bus.abort), 0);
        check("async_w_data", int'(bus.w_data), 0);
        check("async_grant_id", int'(bus.grant_id), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        push(2, 8'h77, 1); push(1, 8'h88, 1);
        wait_wr("post_reset_first", c);
        check("post_reset_gid", int'(bus.grant_id), 1);
        check("post_reset_data", int'(bus.w_data), 8'h88);
        repeat (10) @(posedge clk);

        // Randomized traffic, backpressure and gaps
        gaps_en = 1'b1;
        repeat (3000) begin
            @(posedge clk); #2;
            bus.tx_full = ($urandom % 5 == 0);
            for (int i = 0; i < N; i++) begin
                if (head[i] >= tail[i] && ($urandom % 3 == 0)) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
        end
        gaps_en     = 1'b0;
        bus.tx_full = 1'b0;
        repeat (200) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (`w_data`/`wr_uart`, back-pressured by `tx_full`) between N_REQ independent message sources, e.g. the game-event encoder and the card-state encoder.
- Grants are round-robin and frame-atomic: once a requester is granted, it keeps the UART until its last byte is accepted.
- A stalled frame is aborted after a programmable timeout, so one source cannot lock the link.
- Sits between the message encoders and the `uart` instance, in the `clk` domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, consecutive idle cycles of the granted requester mid-frame before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8*i+7:8*i].
- req_last  input  N_REQ  marks the final byte of a frame; qualified by req_valid.
- req_ready  output  N_REQ  byte accepted this cycle.
- tx_full  input  1  UART TX FIFO full.
- wr_uart  output  1  write strobe to the UART TX FIFO.
- w_data  output  8  byte to the UART.
- grant_id  output  $clog2(N_REQ)  index of the current or last granted requester.
- busy  output  1  high whenever state is not IDLE.
- abort  output  1  one-cycle pulse when a frame is aborted by timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=N_REQ-1, grant_id=0, timeout counter=0, checksum=0.
  - All outputs 0: wr_uart, req_ready, busy, abort, w_data.
- States: IDLE, SEND, CHK. CHK exists only with the optional feature.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr+1, wrapping modulo N_REQ.
  - Register the winner as grant_id, clear the timeout counter and checksum, and go to SEND.
  - No byte is accepted in IDLE. The first byte is written at the earliest 1 cycle after req_valid is sampled.
- SEND, with g=grant_id:
  - Combinational: accept = req_valid[g] & ~tx_full.
  - Combinational: wr_uart=accept, w_data=req_data[g], req_ready[g]=accept.
  - Combinational: req_ready of every other requester = 0.
  - While tx_full=1, nothing is written and the requester must hold its byte; tx_full stalls do not advance the timeout.
  - accept & req_last[g]: rr_ptr<=g. Next state is CHK if the feature is enabled, otherwise IDLE.
  - Timeout counter: cleared on every accept; increments each cycle with req_valid[g]=0.
  - When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): abort pulses for 1 cycle, rr_ptr<=g, next state IDLE, no checksum byte is sent.
- The grant never changes mid-frame. Requests from other requesters wait.
- Back-to-back frames: the IDLE cycle between frames is mandatory, so the minimum gap is 1 cycle.
  - If the same requester is the only one requesting, it is re-granted.
  - Otherwise round-robin gives the next requester priority.
- w_data is don't-care when wr_uart=0, but must equal 0 in IDLE.
- busy=1 in SEND and CHK.
- Single-byte frame (req_last on the first byte) is legal.

Optional Feature:
- Macro: UART_ARB_CHKSUM_EN.
- Defined:
  - The arbiter keeps a running XOR over all accepted bytes of the frame; checksum is cleared on grant.
  - After the last byte it enters CHK.
  - In CHK: wr_uart=~tx_full, w_data=checksum, all req_ready=0.
  - When the write occurs, go to IDLE. CHK has no timeout.
- Undefined: the CHK state and checksum register are absent; SEND goes directly to IDLE after the last byte.

Test Plan:
- Reset, then req_valid=0 for 10 cycles → wr_uart=0, busy=0, grant_id=0 throughout.
- Requester 2 sends frame {0x41, 0x42, 0x43 last} with tx_full=0 → wr_uart high for 3 consecutive cycles starting 1 cycle after the request, w_data 0x41, 0x42, 0x43, grant_id=2. With UART_ARB_CHKSUM_EN, a 4th write of 0x40 follows.
- Requesters 0 and 3 request simultaneously, each sending 2-byte frames, rr_ptr=N_REQ-1 after reset → requester 0 is served first and completes its full frame, then requester 3. On repeated contention the order alternates 0,3,0,3.
- tx_full asserted for 5 cycles mid-frame → wr_uart=0 and req_ready=0 during the stall, no abort, the stalled byte is written when tx_full drops, and the byte sequence is intact.
- TIMEOUT_CYCLES=8, requester 1 sends 1 byte (not last) then drops req_valid → abort pulses exactly 8 cycles after the last accept, busy falls on the next cycle, and requester 2 pending is granted next.
- Assert rst low during SEND → all outputs 0 immediately (asynchronous). After release, the arbiter starts in IDLE and the first grant goes to the lowest-index requester that is requesting.
